// File: rtl/debounce_repeat.sv
// Push-button conditioner: two-flop synchronizer, tick-counted debounce and
// keyboard-style auto-repeat producing single-clock step strobes.
module debounce_repeat #(
  parameter int N            = 8,
  parameter int STABLE_TICKS = 4,
  parameter int REPEAT_DELAY = 32,
  parameter int REPEAT_RATE  = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic button_raw,
  output logic button,
  output logic pressed,
  output logic released,
  output logic step
);

  // Zero-valued stable/rate parameters are treated as one tick.
  localparam int STB  = (STABLE_TICKS < 1) ? 1 : STABLE_TICKS;
  localparam int RATE = (REPEAT_RATE < 1) ? 1 : REPEAT_RATE;
  localparam int DLY  = (REPEAT_DELAY < 1) ? 1 : REPEAT_DELAY;

  localparam logic [N-1:0] DB_LAST   = N'(STB - 1);
  localparam logic [N-1:0] RATE_LAST = N'(RATE - 1);
  localparam logic [N-1:0] DLY_LAST  = N'(DLY - 1);
  localparam bit           REP_EN    = (REPEAT_DELAY != 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DELAY  = 2'd1,
    S_REPEAT = 2'd2
  } state_t;

  logic         r_sync_p0;
  logic         r_sync_p1;
  logic [N-1:0] r_db_cnt;
  logic [N-1:0] w_db_cnt_nxt;
  logic         w_db_flip;
  logic         w_rise;
  logic         w_fall;

  logic         r_button;
  logic         r_pressed;
  logic         r_released;
  logic         r_step;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [N-1:0] r_rep_cnt;
  logic [N-1:0] w_rep_cnt_nxt;
  logic         w_step_nxt;

  // ---- stage p0/p1: metastability synchronizer, runs every clock ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync_p0 <= 1'b0;
      r_sync_p1 <= 1'b0;
    end else begin
      r_sync_p0 <= button_raw;
      r_sync_p1 <= r_sync_p0;
    end
  end

  // ---- debounce: count consecutive ticks of disagreement ----
  always_comb begin
    w_db_cnt_nxt = r_db_cnt;
    w_db_flip    = 1'b0;
    if (tick) begin
      if (r_sync_p1 != r_button) begin
        if (r_db_cnt == DB_LAST) begin
          w_db_flip    = 1'b1;
          w_db_cnt_nxt = '0;
        end else begin
          w_db_cnt_nxt = r_db_cnt + N'(1);
        end
      end else begin
        w_db_cnt_nxt = '0;
      end
    end
  end

  assign w_rise = w_db_flip & ~r_button;
  assign w_fall = w_db_flip &  r_button;

  // ---- repeat FSM: a debounced fall overrides any due repeat ----
  always_comb begin
    w_state_nxt   = r_state;
    w_rep_cnt_nxt = r_rep_cnt;
    w_step_nxt    = 1'b0;
    if (w_fall) begin
      w_state_nxt   = S_IDLE;
      w_rep_cnt_nxt = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_rise) begin
            w_step_nxt    = 1'b1;
            w_rep_cnt_nxt = '0;
            w_state_nxt   = S_DELAY;
          end
        end
        S_DELAY: begin
          if (tick && REP_EN) begin
            if (r_rep_cnt == DLY_LAST) begin
              w_step_nxt    = 1'b1;
              w_rep_cnt_nxt = '0;
              w_state_nxt   = S_REPEAT;
            end else begin
              w_rep_cnt_nxt = r_rep_cnt + N'(1);
            end
          end
        end
        S_REPEAT: begin
          if (tick) begin
            if (r_rep_cnt == RATE_LAST) begin
              w_step_nxt    = 1'b1;
              w_rep_cnt_nxt = '0;
            end else begin
              w_rep_cnt_nxt = r_rep_cnt + N'(1);
            end
          end
        end
        default: begin
          w_state_nxt   = S_IDLE;
          w_rep_cnt_nxt = '0;
        end
      endcase
    end
  end

  // ---- output register stage ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_db_cnt   <= '0;
      r_button   <= 1'b0;
      r_pressed  <= 1'b0;
      r_released <= 1'b0;
      r_step     <= 1'b0;
      r_state    <= S_IDLE;
      r_rep_cnt  <= '0;
    end else begin
      r_db_cnt   <= w_db_cnt_nxt;
      r_button   <= r_button ^ w_db_flip;
      r_pressed  <= w_rise;
      r_released <= w_fall;
      r_step     <= w_step_nxt;
      r_state    <= w_state_nxt;
      r_rep_cnt  <= w_rep_cnt_nxt;
    end
  end

  assign button   = r_button;
  assign pressed  = r_pressed;
  assign released = r_released;
  assign step     = r_step;

endmodule

// File: tb/tb_debounce_repeat.sv
// Bench for debounce_repeat: directed scenarios plus randomized traffic,
// checked against a tick-arithmetic behavioural model.
module tb_debounce_repeat;
  localparam int N    = 8;
  localparam int STB  = 4;
  localparam int DLY  = 8;
  localparam int RATE = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0;
  logic button_raw = 1'b0;
  logic button, pressed, released, step;

  int checks = 0;
  int errors = 0;

  debounce_repeat #(
    .N(N), .STABLE_TICKS(STB), .REPEAT_DELAY(DLY), .REPEAT_RATE(RATE)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .button_raw(button_raw),
    .button(button), .pressed(pressed), .released(released), .step(step)
  );

  always #5 clk = ~clk;

  // Reference model: debounce as a run of disagreeing ticks, repeat steps
  // from the number of ticks elapsed since the press.
  logic m_s0 = 1'b0, m_s1 = 1'b0, m_button = 1'b0;
  logic m_pressed = 1'b0, m_released = 1'b0, m_step = 1'b0;
  int   m_run = 0, m_tsp = 0;
  logic n_s0, n_s1, n_button, n_pressed, n_released, n_step, n_flip;
  int   n_run, n_tsp;

  always_comb begin
    n_s0 = button_raw; n_s1 = m_s0; n_button = m_button;
    n_pressed = 1'b0; n_released = 1'b0; n_step = 1'b0; n_flip = 1'b0;
    n_run = m_run; n_tsp = m_tsp;
    if (tick) begin
      if (m_s1 != m_button) begin
        n_run = m_run + 1;
        if (n_run >= STB) begin n_flip = 1'b1; n_run = 0; end
      end else begin
        n_run = 0;
      end
    end
    if (n_flip && !m_button) begin
      n_button = 1'b1; n_pressed = 1'b1; n_step = 1'b1; n_tsp = 0;
    end else if (n_flip) begin
      n_button = 1'b0; n_released = 1'b1;
    end else if (m_button && tick) begin
      n_tsp = m_tsp + 1;
      if (DLY != 0 && (n_tsp == DLY || (n_tsp > DLY && (n_tsp - DLY) % RATE == 0)))
        n_step = 1'b1;
    end
    if (rst) begin
      n_s0 = 1'b0; n_s1 = 1'b0; n_button = 1'b0; n_pressed = 1'b0;
      n_released = 1'b0; n_step = 1'b0; n_run = 0; n_tsp = 0;
    end
  end

  always @(posedge clk) begin
    m_s0 <= n_s0; m_s1 <= n_s1; m_button <= n_button;
    m_pressed <= n_pressed; m_released <= n_released; m_step <= n_step;
    m_run <= n_run; m_tsp <= n_tsp;
  end

  logic [3:0] dut_o, exp_o;
  assign dut_o = {button, pressed, released, step};
  assign exp_o = {m_button, m_pressed, m_released, m_step};

  task automatic do_reset();
    rst = 1'b1; button_raw = 1'b0; tick = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick = 1'($urandom_range(0, 1));
      button_raw = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      checks++;
      if (dut_o !== 4'b0000) begin
        errors++;
        $display("FAIL reset cyc=%0d got=%b expected=%b", k, dut_o, 4'b0000);
      end
    end
    rst = 1'b0; button_raw = 1'b0;
  endtask

  task automatic test_clean_press();
    logic eb, ep;
    do_reset();
    button_raw = 1'b1; tick = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      eb = (k >= 6); ep = (k == 6);
      checks++;
      if ({button, pressed, released, step} !== {eb, ep, 1'b0, ep}) begin
        errors++;
        $display("FAIL clean_press edge=%0d got=%b expected=%b", k, dut_o, {eb, ep, 1'b0, ep});
      end
      checks++;
      if (dut_o !== exp_o) begin
        errors++;
        $display("FAIL clean_press_model edge=%0d got=%b expected=%b", k, dut_o, exp_o);
      end
    end
  endtask

  task automatic test_auto_repeat();
    logic es;
    do_reset();
    button_raw = 1'b1; tick = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      @(posedge clk); #1;
      es = (k == 6 || k == 14 || k == 18 || k == 22 || k == 26 || k == 30);
      checks++;
      if (step !== es) begin
        errors++;
        $display("FAIL auto_repeat edge=%0d step got=%b expected=%b", k, step, es);
      end
      checks++;
      if (dut_o !== exp_o) begin
        errors++;
        $display("FAIL auto_repeat_model edge=%0d got=%b expected=%b", k, dut_o, exp_o);
      end
    end
  endtask

  task automatic test_bounce();
    do_reset();
    tick = 1'b1;
    for (int k = 0; k < 52; k++) begin
      button_raw = (k < 40) ? ((k / 2) % 2 == 0) : 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({button, pressed, step} !== 3'b000) begin
        errors++;
        $display("FAIL bounce cyc=%0d got=%b expected=000", k, {button, pressed, step});
      end
      checks++;
      if (dut_o !== exp_o) begin
        errors++;
        $display("FAIL bounce_model cyc=%0d got=%b expected=%b", k, dut_o, exp_o);
      end
    end
  endtask

  task automatic test_release_priority();
    int fall_edge;
    fall_edge = 18 + 4 * $urandom_range(0, 3);
    do_reset();
    button_raw = 1'b1; tick = 1'b1;
    for (int k = 1; k <= fall_edge + 20; k++) begin
      @(posedge clk); #1;
      if (k == fall_edge) begin
        checks++;
        if ({button, released, step} !== 3'b010) begin
          errors++;
          $display("FAIL release_priority edge=%0d btn/rel/step got=%b expected=010", k, {button, released, step});
        end
      end else if (k > fall_edge) begin
        checks++;
        if (step !== 1'b0) begin
          errors++;
          $display("FAIL release_after edge=%0d step got=%b expected=0", k, step);
        end
      end
      checks++;
      if (dut_o !== exp_o) begin
        errors++;
        $display("FAIL release_model edge=%0d got=%b expected=%b", k, dut_o, exp_o);
      end
      if (k == fall_edge - 6) button_raw = 1'b0;
    end
  endtask

  task automatic test_slow_tick();
    int phase, nt;
    logic eb, ep;
    do_reset();
    phase = $urandom_range(0, 9);
    nt = 0;
    button_raw = 1'b1;
    for (int k = 1; k <= 90; k++) begin
      tick = ((k + phase) % 10 == 0);
      @(posedge clk); #1;
      ep = 1'b0;
      if (tick && k >= 3) begin
        nt++;
        ep = (nt == STB);
      end
      eb = (nt >= STB);
      checks++;
      if (dut_o !== {eb, ep, 1'b0, ep}) begin
        errors++;
        $display("FAIL slow_tick edge=%0d tick=%b got=%b expected=%b", k, tick, dut_o, {eb, ep, 1'b0, ep});
      end
      checks++;
      if (dut_o !== exp_o) begin
        errors++;
        $display("FAIL slow_tick_model edge=%0d got=%b expected=%b", k, dut_o, exp_o);
      end
    end
  endtask

  task automatic test_reset_mid_repeat();
    logic eb, ep;
    do_reset();
    button_raw = 1'b1; tick = 1'b1;
    for (int k = 1; k <= 19; k++) begin
      @(posedge clk); #1;
      checks++;
      if (dut_o !== exp_o) begin
        errors++;
        $display("FAIL mid_repeat_model edge=%0d got=%b expected=%b", k, dut_o, exp_o);
      end
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (dut_o !== 4'b0000) begin
      errors++;
      $display("FAIL mid_repeat_reset got=%b expected=0000", dut_o);
    end
    for (int k = 21; k <= 28; k++) begin
      @(posedge clk); #1;
      eb = (k >= 26); ep = (k == 26);
      checks++;
      if ({button, pressed, step} !== {eb, ep, ep}) begin
        errors++;
        $display("FAIL mid_repeat_repress edge=%0d got=%b expected=%b", k, {button, pressed, step}, {eb, ep, ep});
      end
    end
  endtask

  task automatic test_random();
    int seg;
    do_reset();
    seg = 0;
    for (int k = 0; k < 3000; k++) begin
      if (seg == 0) begin
        button_raw = 1'($urandom_range(0, 1));
        seg = ($urandom_range(0, 7) == 0) ? $urandom_range(20, 80) : $urandom_range(1, 14);
      end
      seg--;
      tick = ($urandom_range(0, 2) != 0);
      rst = ($urandom_range(0, 499) == 0);
      @(posedge clk); #1;
      checks++;
      if (dut_o !== exp_o) begin
        errors++;
        $display("FAIL random cyc=%0d got=%b expected=%b", k, dut_o, exp_o);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_auto_repeat();
    test_bounce();
    test_release_priority();
    test_slow_tick();
    test_reset_mid_repeat();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
